// File: rtl/rvne_pkg.sv
// RVNE layer sequencer shared types: opcodes, funct3 codes,
// sequencer states and the latched command bundle.
package rvne_pkg;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_R      = 7'b0110011,
      OP_BRANCH = 7'b1100011,
      OP_IMM    = 7'b0010011,
      OP_VLOAD  = 7'b0000010,
      OP_NEURO  = 7'b0110010
   } opcode_e;

   localparam logic [2:0] F3_NSR_ST = 3'b111;
   localparam logic [2:0] F3_NACC   = 3'b001;

   localparam logic [1:0] VL_RESERVED = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SVR,
      S_WVR,
      S_NACC,
      S_NSR,
      S_DONE
   } seq_state_e;

   typedef struct packed {
      logic [1:0] vl;
      logic [4:0] base_w;
      logic [4:0] base_s;
      logic [4:0] base_o;
   } cmd_t;

endpackage

// File: rtl/rvne_layer_sequencer_inst_pack.sv
// Combinational I/R-type instruction word packer.
// The caller selects format and supplies every field.
module rvne_inst_pack
   import rvne_pkg::*;
(
   input  logic        fmt_r,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [11:0] imm,
   output logic [31:0] word
);

   assign word = fmt_r ? {funct7, rs2, rs1, funct3, rd, opcode}
                       : {imm, rs1, funct3, rd, opcode};

endmodule

// File: rtl/rvne_layer_sequencer.sv
// Expands a neuron-layer command into an SVR load followed by
// WVR/NACC/NSR triples, one per neuron, over valid/ready.
module rvne_layer_sequencer
   import rvne_pkg::*;
#(
   parameter int IMM_STRIDE = 16,
   parameter int N_W        = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [N_W-1:0] cmd_n,
   input  logic [1:0]     cmd_vl,
   input  logic [4:0]     cmd_base_w,
   input  logic [4:0]     cmd_base_s,
   input  logic [4:0]     cmd_base_o,
   output logic           inst_valid,
   input  logic           inst_ready,
   output logic [31:0]    inst_data,
   output logic           done,
   output logic           err
);

   seq_state_e     state, nstate;
   cmd_t           cmd_q, ncmd;
   logic [N_W-1:0] n_q, nn;
   logic [N_W-1:0] i_q, ni;
   logic           nerr;
   logic           emit;

   logic        fmt_r;
   logic [6:0]  op;
   logic [2:0]  f3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [11:0] imm;
   logic [31:0] word;

   always_comb begin
      nstate = state;
      ncmd   = cmd_q;
      nn     = n_q;
      ni     = i_q;
      nerr   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               ncmd = '{vl: cmd_vl, base_w: cmd_base_w,
                        base_s: cmd_base_s, base_o: cmd_base_o};
               nn   = cmd_n;
               ni   = '0;
               if (cmd_vl == VL_RESERVED) begin
                  nstate = S_DONE;
                  nerr   = 1'b1;
               end else if (cmd_n == '0) begin
                  nstate = S_DONE;
               end else begin
                  nstate = S_SVR;
               end
            end
         end
         S_SVR:  if (inst_ready) nstate = S_WVR;
         S_WVR:  if (inst_ready) nstate = S_NACC;
         S_NACC: if (inst_ready) nstate = S_NSR;
         S_NSR: begin
            if (inst_ready) begin
               ni     = i_q + 1'b1;
               nstate = (i_q + 1'b1 < n_q) ? S_WVR : S_DONE;
            end
         end
         S_DONE:  nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
   end

   // Fields come from the next state so the word is registered
   // alongside inst_valid and holds while stalled.
   always_comb begin
      fmt_r = 1'b0;
      op    = OP_VLOAD;
      f3    = 3'b000;
      rs1   = 5'd0;
      rs2   = 5'd0;
      imm   = 12'd0;
      unique case (nstate)
         S_SVR: begin
            f3  = 3'd3 + {1'b0, ncmd.vl};
            rs1 = ncmd.base_s;
         end
         S_WVR: begin
            f3  = {1'b0, ncmd.vl};
            rs1 = ncmd.base_w;
            imm = 12'(32'(ni) * 32'(IMM_STRIDE));
         end
         S_NACC: begin
            fmt_r = 1'b1;
            op    = OP_NEURO;
            f3    = F3_NACC;
         end
         S_NSR: begin
            fmt_r = 1'b1;
            op    = OP_R;
            f3    = F3_NSR_ST;
            rs1   = ncmd.base_o;
            rs2   = 5'(ni);
         end
         default: ;
      endcase
   end

   assign emit = (nstate == S_SVR) || (nstate == S_WVR) ||
                 (nstate == S_NACC) || (nstate == S_NSR);

   rvne_inst_pack u_pack (
      .fmt_r  (fmt_r),
      .opcode (op),
      .funct3 (f3),
      .funct7 (7'd0),
      .rd     (5'd0),
      .rs1    (rs1),
      .rs2    (rs2),
      .imm    (imm),
      .word   (word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cmd_q      <= '0;
         n_q        <= '0;
         i_q        <= '0;
         cmd_ready  <= 1'b0;
         inst_valid <= 1'b0;
         inst_data  <= 32'd0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= nstate;
         cmd_q      <= ncmd;
         n_q        <= nn;
         i_q        <= ni;
         cmd_ready  <= (nstate == S_IDLE);
         inst_valid <= emit;
         inst_data  <= emit ? word : 32'd0;
         done       <= (nstate == S_DONE);
         err        <= nerr;
      end
   end

endmodule

// File: tb/tb_rvne_layer_sequencer.sv
// Directed + randomized bench for rvne_layer_sequencer with an
// instruction-list reference model built from the encoding rules.
module tb_rvne_layer_sequencer;

  localparam int STRIDE = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_n;
  logic [1:0]  cmd_vl;
  logic [4:0]  cmd_base_w;
  logic [4:0]  cmd_base_s;
  logic [4:0]  cmd_base_o;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  rvne_layer_sequencer #(.IMM_STRIDE(STRIDE), .N_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_n      (cmd_n),
    .cmd_vl     (cmd_vl),
    .cmd_base_w (cmd_base_w),
    .cmd_base_s (cmd_base_s),
    .cmd_base_o (cmd_base_o),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_data  (inst_data),
    .done       (done),
    .err        (err)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1,
                                        int f3, int op);
    return 32'((imm << 20) + (rs1 << 15) + (f3 << 12) + op);
  endfunction

  task automatic build_exp(int n, int vl, int bs, int bw,
                           int bo);
    exp_q.delete();
    if (vl == 3 || n == 0) return;
    exp_q.push_back(enc_i(0, bs, 3 + vl, 'h02));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(enc_i((i * STRIDE) % 4096, bw, vl, 'h02));
      exp_q.push_back(32'h0000_1032);
      exp_q.push_back(32'((i % 32) << 20) + 32'(bo << 15) +
                      32'(7 << 12) + 32'h33);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(int n, int vl, int bs, int bw, int bo,
                         bit rnd);
    int wait_cyc;
    int k;
    int cyc;
    int limit;
    bit stalled;
    logic [31:0] held;
    build_exp(n, vl, bs, bw, bo);
    got_q.delete();
    wait_cyc = 0;
    while (cmd_ready !== 1'b1 && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_n      = 6'(n);
    cmd_vl     = 2'(vl);
    cmd_base_s = 5'(bs);
    cmd_base_w = 5'(bw);
    cmd_base_o = 5'(bo);
    cmd_valid  = 1'b1;
    inst_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("ready_after_accept", cmd_ready, 1'b0);
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    limit = 4 * exp_q.size() + 40;
    while (k < exp_q.size() && cyc < limit) begin
      chk("valid_in_stream", inst_valid, 1'b1);
      chk("no_done_in_stream", done, 1'b0);
      if (stalled) chk("stall_stable", inst_data, held);
      inst_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inst_ready) begin
        got_q.push_back(inst_data);
        chk("inst_word", inst_data, exp_q[k]);
        k++;
        stalled = 1'b0;
      end else begin
        held = inst_data;
        stalled = 1'b1;
      end
      tick();
      cyc++;
    end
    chk("word_count", k, exp_q.size());
    inst_ready = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("err_pulse", err, (vl == 3) ? 1'b1 : 1'b0);
    chk("valid_after_last", inst_valid, 1'b0);
    chk("ready_during_done", cmd_ready, 1'b0);
    tick();
    chk("ready_back", cmd_ready, 1'b1);
    chk("done_one_cycle", done, 1'b0);
    chk("err_one_cycle", err, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_n      = '0;
    cmd_vl     = '0;
    cmd_base_w = '0;
    cmd_base_s = '0;
    cmd_base_o = '0;
    inst_ready = 1'b0;

    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", cmd_ready, 1'b1);

    run_cmd(2, 1, 3, 4, 5, 1'b0);
    run_cmd(2, 1, 3, 4, 5, 1'b1);
    run_cmd(0, 1, 7, 8, 9, 1'b0);
    run_cmd(4, 3, 1, 2, 3, 1'b0);

    run_cmd(63, 2, 10, 11, 12, 1'b0);
    chk("n63_total", got_q.size(), 190);
    w = got_q[1 + 3 * 31];
    chk("imm_i31", w[31:20], 12'hF80);
    w = got_q[1 + 3 * 32];
    chk("imm_wrap_i32", w[31:20], 12'h000);
    w = got_q[1 + 3 * 40 + 2];
    chk("rs2_i40", w[24:20], 5'd8);

    for (int t = 0; t < 8; t++)
      run_cmd(int'($urandom_range(0, 10)),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), 1'b1);

    cmd_n      = 6'd5;
    cmd_vl     = 2'd0;
    cmd_base_s = 5'd1;
    cmd_base_w = 5'd2;
    cmd_base_o = 5'd3;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
    inst_ready = 1'b1;
    repeat (7) tick();
    chk("mid_valid_before_rst", inst_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inst_ready = 1'b0;
    chk("abort_valid", inst_valid, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_ready", cmd_ready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_no_done", done, 1'b0);
      chk("abort_no_valid", inst_valid, 1'b0);
    end
    run_cmd(1, 2, 6, 7, 8, 1'b1);
    chk("post_abort_words", got_q.size(), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
